// File: rtl/wb_arbiter_n_pkg.sv
// ============================================================================
// Module : wb_arbiter_n_pkg
// Brief  : Shared widths, source identifiers and sizing helpers for the
//          writeback arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_arbiter_n_pkg;

  localparam int WB_DST_W = 5;
  localparam int XLEN     = 64;

  typedef enum logic [1:0] {
    WB_SRC_IP0  = 2'd0,
    WB_SRC_LSP  = 2'd1,
    WB_SRC_TRAP = 2'd2,
    WB_SRC_MDU  = 2'd3
  } wb_src_e;

  // Wait counters never shrink below 3 bits, even for tiny limits.
  function automatic int wait_cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_n_rr_pick_n.sv
// ============================================================================
// Module : rr_pick_n
// Brief  : Rotating-priority first-one finder: first set mask bit at or after
//          ptr_i (wrapping), returned as one-hot and index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick_n #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int off = 0; off < N; off++) begin
      int j;
      j = int'(ptr_i) + off;
      if (j >= N) j = j - N;
      if (!found_o && mask_i[j]) begin
        found_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter_n.sv
// ============================================================================
// Module : wb_arbiter_n
// Brief  : N-source to M-port register-file writeback arbiter with round-robin,
//          starvation override, dst-collision skipping and retire counting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_arbiter_n
  import wb_arbiter_n_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int NUM_WPORTS   = 1,
  parameter int STARVE_LIMIT = 7,
  parameter int REG_OUT      = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC-1:0]              src_wb_en,
  input  logic [NUM_SRC*WB_DST_W-1:0]     src_dst,
  input  logic [NUM_SRC*XLEN-1:0]         src_result,
  input  logic [NUM_SRC*XLEN-1:0]         src_pc,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [NUM_WPORTS-1:0]           rf_wen,
  output logic [NUM_WPORTS*WB_DST_W-1:0]  rf_wdst,
  output logic [NUM_WPORTS*XLEN-1:0]      rf_wdata,
  output logic [$clog2(NUM_SRC+1)-1:0]    wb_trap_instret,
  output logic                            starve_active
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = wait_cnt_width(STARVE_LIMIT);
  localparam int PW = $clog2(NUM_SRC + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  logic [WB_DST_W-1:0] w_dst    [NUM_SRC];
  logic [XLEN-1:0]     w_res    [NUM_SRC];
  logic [NUM_SRC-1:0]  w_req, w_rwowb, w_grant, w_starve_oh, w_starve_coll;
  logic                w_starve_any;
  logic [IW-1:0]       w_starve_idx;
  logic [CW-1:0]       wait_q   [NUM_SRC];
  logic [CW-1:0]       wait_d   [NUM_SRC];
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_WPORTS-1:0][NUM_SRC-1:0] w_avail, w_pick_oh;
  logic [NUM_WPORTS-1:0][IW-1:0]      w_pick_idx;
  logic [NUM_WPORTS-1:0]              w_pick_found;

  logic [NUM_WPORTS-1:0]              w_wen;
  logic [NUM_WPORTS*WB_DST_W-1:0]     w_wdst;
  logic [NUM_WPORTS*XLEN-1:0]         w_wdata;
  logic                               w_rot_any;
  logic [IW-1:0]                      w_rot_last;
  logic [PW-1:0]                      w_instret;
  logic                               w_unused_pc;

  assign w_unused_pc = ^src_pc;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign w_dst[i]   = src_dst[i*WB_DST_W +: WB_DST_W];
    assign w_res[i]   = src_result[i*XLEN +: XLEN];
    assign w_req[i]   = !rst && src_valid[i] && src_wb_en[i] && (w_dst[i] != '0);
    assign w_rwowb[i] = !rst && src_valid[i] && !w_req[i];
  end

  // Lowest-index source sitting at the wait limit jumps the rotation.
  always_comb begin
    w_starve_any  = 1'b0;
    w_starve_idx  = '0;
    w_starve_oh   = '0;
    w_starve_coll = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_req[i] && wait_q[i] == C_LIMIT) begin
        w_starve_any = 1'b1;
        w_starve_idx = IW'(i);
      end
    end
    w_starve_oh[w_starve_idx] = w_starve_any;
    for (int i = 0; i < NUM_SRC; i++)
      w_starve_coll[i] = w_starve_any && (w_dst[i] == w_dst[w_starve_idx]);
  end

  assign w_avail[0] = w_req & ~w_starve_coll;

  for (genvar k = 0; k < NUM_WPORTS; k++) begin : g_pick
    rr_pick_n #(.N(NUM_SRC), .IW(IW)) u_pick (
      .mask_i   (w_avail[k]),
      .ptr_i    (rr_ptr_q),
      .onehot_o (w_pick_oh[k]),
      .idx_o    (w_pick_idx[k]),
      .found_o  (w_pick_found[k])
    );
    if (k + 1 < NUM_WPORTS) begin : g_next
      logic [NUM_SRC-1:0] w_coll;
      always_comb begin
        w_coll = '0;
        for (int i = 0; i < NUM_SRC; i++)
          w_coll[i] = w_pick_found[k] && (w_dst[i] == w_dst[w_pick_idx[k]]);
      end
      assign w_avail[k+1] = w_avail[k] & ~w_coll;
    end
  end

  // Port 0 belongs to the starved source when one exists; rotation picks shift up.
  always_comb begin
    logic [IW-1:0] src;
    logic          vld;
    int            k;
    w_grant    = w_starve_oh;
    w_wen      = '0;
    w_wdst     = '0;
    w_wdata    = '0;
    w_rot_any  = 1'b0;
    w_rot_last = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      src = '0;
      vld = 1'b0;
      k   = 0;
      if (w_starve_any && p == 0) begin
        vld = 1'b1;
        src = w_starve_idx;
      end else begin
        k = w_starve_any ? p - 1 : p;
        if (w_pick_found[k]) begin
          vld        = 1'b1;
          src        = w_pick_idx[k];
          w_grant    = w_grant | w_pick_oh[k];
          w_rot_any  = 1'b1;
          w_rot_last = w_pick_idx[k];
        end
      end
      if (vld) begin
        w_wen[p]                         = 1'b1;
        w_wdst[p*WB_DST_W +: WB_DST_W]   = w_dst[src];
        w_wdata[p*XLEN +: XLEN]          = w_res[src];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_rot_any)
      rr_ptr_d = (w_rot_last == IW'(NUM_SRC - 1)) ? '0 : w_rot_last + 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_req[i] || w_grant[i]) wait_d[i] = '0;
      else if (wait_q[i] != C_LIMIT) wait_d[i] = wait_q[i] + 1'b1;
      else wait_d[i] = wait_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_SRC; i++) wait_q[i] <= wait_d[i];
    end
  end

  always_comb begin
    w_instret = '0;
    for (int i = 0; i < NUM_SRC; i++)
      w_instret = w_instret + PW'(w_grant[i] | w_rwowb[i]);
  end

  assign src_ready       = rst ? '0 : (w_grant | w_rwowb | ~src_valid);
  assign wb_trap_instret = w_instret;
  assign starve_active   = w_starve_any;

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_WPORTS-1:0]          rf_wen_q;
    logic [NUM_WPORTS*WB_DST_W-1:0] rf_wdst_q;
    logic [NUM_WPORTS*XLEN-1:0]     rf_wdata_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rf_wen_q   <= '0;
        rf_wdst_q  <= '0;
        rf_wdata_q <= '0;
      end else begin
        rf_wen_q   <= w_wen;
        rf_wdst_q  <= w_wdst;
        rf_wdata_q <= w_wdata;
      end
    end
    assign rf_wen   = rf_wen_q;
    assign rf_wdst  = rf_wdst_q;
    assign rf_wdata = rf_wdata_q;
  end else begin : g_comb_out
    assign rf_wen   = w_wen;
    assign rf_wdst  = w_wdst;
    assign rf_wdata = w_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_n.sv
// ============================================================================
// Module : tb_wb_arbiter_n
// Brief  : Randomized scoreboard bench for wb_arbiter_n against a queue/array
//          reference model of the arbitration rules.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter_n;
  import wb_arbiter_n_pkg::*;

  localparam int N    = 4;
  localparam int W    = 2;
  localparam int LIM  = 2;
  localparam int RO   = 1;
  localparam int NCYC = 260;

  typedef struct {
    int          cyc;
    int          port;
    logic [4:0]  dst;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    logic [N-1:0] rdy;
    int           inst;
    logic         st;
  } stat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [N-1:0]          src_valid, src_wb_en, src_ready;
  logic [N*5-1:0]        src_dst;
  logic [N*64-1:0]       src_result, src_pc;
  logic [W-1:0]          rf_wen;
  logic [W*5-1:0]        rf_wdst;
  logic [W*64-1:0]       rf_wdata;
  logic [$clog2(N+1)-1:0] wb_trap_instret;
  logic                  starve_active;

  wb_arbiter_n #(.NUM_SRC(N), .NUM_WPORTS(W), .STARVE_LIMIT(LIM), .REG_OUT(RO)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_valid       (src_valid),
    .src_wb_en       (src_wb_en),
    .src_dst         (src_dst),
    .src_result      (src_result),
    .src_pc          (src_pc),
    .src_ready       (src_ready),
    .rf_wen          (rf_wen),
    .rf_wdst         (rf_wdst),
    .rf_wdata        (rf_wdata),
    .wb_trap_instret (wb_trap_instret),
    .starve_active   (starve_active)
  );

  int    pass_cnt = 0;
  int    chk_cnt  = 0;
  int    cyc      = -10;
  wr_t   q_rf[$];
  stat_t q_stat[$];

  // Pending transaction per source, held until the model says it was consumed
  bit          p_v  [N];
  bit          p_we [N];
  int          p_dst[N];
  logic [63:0] p_res[N];
  int          m_rr;
  int          m_wait[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
  endtask

  task automatic new_txn(input int i, input int n);
    p_res[i] = {$urandom, $urandom};
    if (n < 40) begin
      p_v[i] = 1'b1; p_we[i] = 1'b1; p_dst[i] = i + 1;
    end else if (n < 80) begin
      p_v[i] = 1'b1; p_we[i] = ($urandom % 4) != 0; p_dst[i] = int'($urandom % 3);
    end else if (n < 140) begin
      p_v[i] = 1'b1; p_we[i] = 1'b1; p_dst[i] = 5 + int'($urandom % 2);
    end else if (n < NCYC - 10) begin
      p_v[i] = ($urandom % 4) != 0; p_we[i] = ($urandom % 5) != 0; p_dst[i] = int'($urandom % 32);
    end else begin
      p_v[i] = 1'b0; p_we[i] = 1'b0; p_dst[i] = 0;
    end
  endtask

  // Driver and reference model
  initial begin
    bit           g[N];
    bit           rq[N];
    bit           used[32];
    int           gl[$];
    int           starve, last_rot, j, e_inst;
    logic [N-1:0] e_rdy;
    rst = 1'b1; src_valid = '0; src_wb_en = '0; src_dst = '0; src_result = '0; src_pc = '0;
    m_rr = 0;
    for (int i = 0; i < N; i++) begin m_wait[i] = 0; new_txn(i, 0); end
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk); #1;
      cyc = n;
      rst = (n < 3) || (n >= 200 && n < 202);
      for (int i = 0; i < N; i++) begin
        src_valid[i]          = p_v[i];
        src_wb_en[i]          = p_we[i];
        src_dst[i*5 +: 5]     = 5'(p_dst[i]);
        src_result[i*64 +: 64] = p_res[i];
        src_pc[i*64 +: 64]    = {32'h0, $urandom};
      end
      e_rdy = '0; e_inst = 0; starve = -1;
      if (rst) begin
        m_rr = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          rq[i] = p_v[i] && p_we[i] && (p_dst[i] != 0);
          g[i]  = 1'b0;
        end
        for (int d = 0; d < 32; d++) used[d] = 1'b0;
        gl.delete();
        for (int i = 0; i < N; i++)
          if (starve < 0 && rq[i] && m_wait[i] >= LIM) starve = i;
        if (starve >= 0) begin
          g[starve] = 1'b1; used[p_dst[starve]] = 1'b1; gl.push_back(starve);
        end
        last_rot = -1;
        for (int off = 0; off < N; off++) begin
          j = (m_rr + off) % N;
          if (gl.size() < W && rq[j] && !g[j] && !used[p_dst[j]]) begin
            g[j] = 1'b1; used[p_dst[j]] = 1'b1; gl.push_back(j); last_rot = j;
          end
        end
        if (last_rot >= 0) m_rr = (last_rot + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (!rq[i] || g[i]) m_wait[i] = 0;
          else if (m_wait[i] < LIM) m_wait[i] = m_wait[i] + 1;
          e_rdy[i] = g[i] || !rq[i];
          if (p_v[i] && e_rdy[i]) e_inst++;
        end
        for (int k = 0; k < gl.size(); k++)
          q_rf.push_back(wr_t'{cyc: n, port: k, dst: 5'(p_dst[gl[k]]), data: p_res[gl[k]]});
      end
      q_stat.push_back(stat_t'{rdy: e_rdy, inst: e_inst, st: (starve >= 0)});
      for (int i = 0; i < N; i++) if (e_rdy[i]) new_txn(i, n + 1);
    end
    @(negedge clk); #1;
    chk("rf_queue_drained", 64'(q_rf.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Monitor: compares DUT outputs against the scoreboard queues mid-cycle
  initial begin
    stat_t st;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (q_stat.size() > 0) begin
        st = q_stat.pop_front();
        chk("src_ready", 64'(src_ready), 64'(st.rdy));
        chk("instret", 64'(wb_trap_instret), 64'(st.inst));
        chk("starve_active", 64'(starve_active), 64'(st.st));
      end
      if (cyc >= 1) begin
        for (int p = 0; p < W; p++) begin
          if (q_rf.size() > 0 && q_rf[0].cyc == cyc - RO && q_rf[0].port == p) begin
            w = q_rf.pop_front();
            chk("rf_wen", 64'(rf_wen[p]), 64'd1);
            chk("rf_wdst", 64'(rf_wdst[p*5 +: 5]), 64'(w.dst));
            chk("rf_wdata", rf_wdata[p*64 +: 64], w.data);
          end else begin
            chk("rf_wen_idle", 64'(rf_wen[p]), 64'd0);
            chk("rf_wdst_idle", 64'(rf_wdst[p*5 +: 5]), 64'd0);
            chk("rf_wdata_idle", rf_wdata[p*64 +: 64], 64'd0);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
